// File: rtl/sum_seg7_display_pkg.sv
// Shared seven-segment constants: digit patterns, blank codes and anode selects.
// All patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [3:0] AN_DIG0 = 4'b1110;
  localparam logic [3:0] AN_DIG1 = 4'b1101;
  localparam logic [3:0] AN_DIG2 = 4'b1011;
  localparam logic [3:0] AN_DIG3 = 4'b0111;

  typedef logic [3:0] digit_t;

  function automatic logic [3:0] anode_for(input logic [1:0] idx);
    case (idx)
      2'd0:    return AN_DIG0;
      2'd1:    return AN_DIG1;
      2'd2:    return AN_DIG2;
      default: return AN_DIG3;
    endcase
  endfunction

endpackage

// File: rtl/sum_seg7_display_if.sv
// Board-side bundle of the seven-segment drive lines (SEG, DP, AN), all active-low.
// master drives the display, slave observes it.
interface sum_seg7_display_if;
  logic [6:0] SEG;
  logic       DP;
  logic [3:0] AN;

  modport master (output SEG, DP, AN);
  modport slave  (input  SEG, DP, AN);
endinterface

// File: rtl/sum_seg7_display_decode.sv
// Digit code to active-low seven-segment pattern; codes above 9 blank the digit.
module seg7_decode
  import seg7_pkg::*;
(
  input  digit_t     digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sum_seg7_display.sv
// Shows the adder SUM (0..31) as two decimal digits on the 4-digit display,
// latching the synchronised value once per refresh frame; DP of digit 1 marks carry.
module sum_seg7_display
  import seg7_pkg::*;
#(
  parameter int REFRESH_COUNT = 100000,
  parameter int BLANK_CYCLES  = 1000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [4:0] SUM,
  output logic [6:0] SEG,
  output logic       DP,
  output logic [3:0] AN
);

  localparam int CNT_W = $clog2(REFRESH_COUNT);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [4:0]       sync1, sync2, value;
  logic             wrap, blank;
  logic [1:0]       tens;
  digit_t           ones, digit;
  logic [6:0]       seg_next;
  logic             dp_next;

  assign wrap  = (cnt == CNT_W'(REFRESH_COUNT - 1));
  assign blank = (cnt <  CNT_W'(BLANK_CYCLES));

  // Binary to two decimal digits by range compare; value never exceeds 31.
  always_comb begin
    tens = 2'd0;
    ones = value[3:0];
    if (value >= 5'd30) begin
      tens = 2'd3;
      ones = 4'(value - 5'd30);
    end else if (value >= 5'd20) begin
      tens = 2'd2;
      ones = 4'(value - 5'd20);
    end else if (value >= 5'd10) begin
      tens = 2'd1;
      ones = 4'(value - 5'd10);
    end
  end

  always_comb begin
    digit   = DIGIT_BLANK;
    dp_next = 1'b1;
    case (idx)
      2'd0: digit = ones;
      2'd1: begin
        digit   = (tens == 2'd0) ? DIGIT_BLANK : {2'b00, tens};
        dp_next = ~value[4];
      end
      default: digit = DIGIT_BLANK;
    endcase
  end

  seg7_decode u_decode (
    .digit (digit),
    .seg   (seg_next)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt   <= '0;
      idx   <= '0;
      sync1 <= '0;
      sync2 <= '0;
      value <= '0;
      SEG   <= SEG_BLANK;
      DP    <= 1'b1;
      AN    <= AN_OFF;
    end else begin
      sync1 <= SUM;
      sync2 <= sync1;
      cnt   <= wrap ? '0 : cnt + 1'b1;
      if (wrap) begin
        idx <= idx + 1'b1;
        // Frame boundary: only reload while the last digit slot ends.
        if (idx == 2'd3)
          value <= sync2;
      end
      SEG <= seg_next;
      DP  <= dp_next;
      AN  <= blank ? AN_OFF : anode_for(idx);
    end
  end

endmodule

// File: tb/tb_sum_seg7_display.sv
// Self-checking bench for sum_seg7_display using a cycle-indexed reference model.
module tb_sum_seg7_display;

  localparam int R = 8;
  localparam int B = 2;
  localparam int FRAME = 4 * R;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] sum = 5'd0;

  sum_seg7_display_if disp ();

  sum_seg7_display #(.REFRESH_COUNT(R), .BLANK_CYCLES(B)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .SUM   (sum),
    .SEG   (disp.SEG),
    .DP    (disp.DP),
    .AN    (disp.AN)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: edges since reset release, value on display, SUM seen at each edge.
  int         k = 0;
  int         shown = 0;
  logic [4:0] hist[$];
  int         last_c = -1;
  int         last_idx = -1;
  logic [6:0] exp_seg;
  logic       exp_dp;
  logic [3:0] exp_an;

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic reset_model();
    k = 0;
    shown = 0;
    hist.delete();
  endtask

  // One clock with reset released: predict outputs from slot position and shown value.
  task automatic tick();
    int c, idx;
    @(posedge clk);
    c   = k % R;
    idx = (k / R) % 4;
    exp_an  = (c < B) ? 4'b1111 : 4'(~(4'b0001 << idx));
    exp_seg = 7'b1111111;
    if (idx == 0) exp_seg = pat(shown % 10);
    else if (idx == 1 && shown / 10 != 0) exp_seg = pat(shown / 10);
    exp_dp = !(idx == 1 && shown >= 16);
    if (k % FRAME == FRAME - 1) shown = int'(hist[k - 2]);
    hist.push_back(sum);
    last_c   = c;
    last_idx = idx;
    k++;
    @(negedge clk);
    check("an", {3'b000, disp.AN}, {3'b000, exp_an});
    if (exp_an != 4'b1111) begin
      check("seg", disp.SEG, exp_seg);
      check("dp", {6'd0, disp.DP}, {6'd0, exp_dp});
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to(input int idx, input int c);
    for (int i = 0; i < FRAME + 2; i++) begin
      tick();
      if (last_idx == idx && last_c == c) return;
    end
    check("run_to_timeout", 7'd1, 7'd0);
  endtask

  task automatic reset_tick();
    @(posedge clk);
    @(negedge clk);
    check("rst_an", {3'b000, disp.AN}, 7'b0001111);
    check("rst_seg", disp.SEG, 7'b1111111);
    check("rst_dp", {6'd0, disp.DP}, 7'd1);
  endtask

  initial begin
    // Reset with SUM=0
    repeat (3) reset_tick();
    rst_n = 1'b1;
    reset_model();
    run_to(0, B);
    check("idle_ones", disp.SEG, 7'b1000000);
    check("idle_an0", {3'b000, disp.AN}, 7'b0001110);
    run_to(1, B);
    check("idle_tens", disp.SEG, 7'b1111111);
    check("idle_dp", {6'd0, disp.DP}, 7'd1);
    run_to(3, B);
    check("idle_an3", {3'b000, disp.AN}, 7'b0000111);

    // 23
    sum = 5'd23;
    run(2 * FRAME);
    run_to(0, 3);
    check("v23_ones", disp.SEG, 7'b0110000);
    run_to(1, 3);
    check("v23_tens", disp.SEG, 7'b0100100);
    check("v23_dp", {6'd0, disp.DP}, 7'd0);

    // Mid-frame changes 7 then 31: old value held until boundary
    sum = 5'd7;
    run(2);
    run_to(1, 7);
    check("hold_tens", disp.SEG, 7'b0100100);
    sum = 5'd31;
    run_to(0, 4);
    check("v31_ones", disp.SEG, 7'b1111001);
    run_to(1, 4);
    check("v31_tens", disp.SEG, 7'b0110000);
    check("v31_dp", {6'd0, disp.DP}, 7'd0);

    // 16
    sum = 5'd16;
    run(2 * FRAME);
    run_to(0, 3);
    check("v16_ones", disp.SEG, 7'b0000010);
    run_to(1, 3);
    check("v16_tens", disp.SEG, 7'b1111001);
    check("v16_dp", {6'd0, disp.DP}, 7'd0);

    // 9: tens suppressed, no carry
    sum = 5'd9;
    run(2 * FRAME);
    run_to(0, 3);
    check("v9_ones", disp.SEG, 7'b0010000);
    run_to(1, 3);
    check("v9_tens", disp.SEG, 7'b1111111);
    check("v9_dp", {6'd0, disp.DP}, 7'd1);

    // SUM changes so it reaches sync stage 2 exactly at the boundary edge
    for (int i = 0; i < FRAME + 1; i++) begin
      if (k % FRAME == FRAME - 3) break;
      tick();
    end
    sum = 5'd27;
    tick();
    sum = 5'd4;
    run_to(0, 3);
    check("edge_ones", disp.SEG, 7'b1111000);
    run_to(1, 3);
    check("edge_tens", disp.SEG, 7'b0100100);
    check("edge_dp", {6'd0, disp.DP}, 7'd0);

    // Randomized SUM changes at random cycles
    for (int i = 0; i < 8 * FRAME; i++) begin
      if ($urandom_range(0, 9) == 0) sum = 5'($urandom_range(0, 31));
      tick();
    end

    // Asynchronous reset mid-slot while showing 23
    sum = 5'd23;
    run(2 * FRAME);
    run_to(0, 4);
    check("pre_rst_ones", disp.SEG, 7'b0110000);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_an", {3'b000, disp.AN}, 7'b0001111);
    check("async_seg", disp.SEG, 7'b1111111);
    check("async_dp", {6'd0, disp.DP}, 7'd1);
    @(negedge clk);
    repeat (2) reset_tick();
    rst_n = 1'b1;
    reset_model();
    run_to(0, 3);
    check("post_rst_ones", disp.SEG, 7'b1000000);
    run_to(1, 3);
    check("post_rst_tens", disp.SEG, 7'b1111111);
    run_to(0, 3);
    check("post_rst_load", disp.SEG, 7'b0110000);
    run_to(1, 3);
    check("post_rst_dp", {6'd0, disp.DP}, 7'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sum_seg7_display.md
Name: sum_seg7_display

Overview:
- Downstream consumer of the 4-bit adder's 5-bit SUM (0..31) on the Basys3 board.
- Synchronises SUM and latches it once per refresh frame, so digits never tear mid-frame.
- Converts the latched value to two decimal digits and time-multiplexes the 4-digit common-anode seven-segment display, with anti-ghosting blanking.
- Lights the decimal point of digit 1 when the carry-out SUM[4] is set.

Parameters:
REFRESH_COUNT  100000  clock cycles per digit slot (1 kHz per digit at 100 MHz); legal range >= 4
BLANK_CYCLES   1000    cycles at the start of each slot with all anodes off; legal range 1 .. REFRESH_COUNT-2

Ports:
CLK    input   1  system clock, rising edge
RST_N  input   1  reset, asynchronous assert, active-low
SUM    input   5  adder result (combinational from switches, asynchronous to CLK)
SEG    output  7  segments {g,f,e,d,c,b,a}, active-low
DP     output  1  decimal point, active-low
AN     output  4  digit anodes, AN[0]=rightmost, active-low

Behaviour:
- Clocking and reset: one clock CLK; reset RST_N is asynchronous and active-low. Deassertion is taken synchronously via the internal logic; no reset synchroniser is required in this block.
- Reset values:
  - AN=4'b1111, SEG=7'b1111111, DP=1.
  - Slot counter=0, digit index=0.
  - Sync stages=0, latched value=0.
- Input sync: two-flop synchroniser on all 5 SUM bits (switch-driven, quasi-static).
- Slot counter:
  - Counts 0..REFRESH_COUNT-1, then wraps to 0.
  - On wrap, digit index advances 0->1->2->3->0.
- Frame latch: when the counter wraps and the index goes 3->0, the latched value loads the synchronised SUM. That wrap cycle is the frame boundary.
- Latency: SUM change to visible on display is at most 2 + 4*REFRESH_COUNT + 1 cycles.
- Digit conversion (combinational from latched value V, 0..31):
  - tens = V/10 (0..3), ones = V%10.
  - Implementation by compare/subtract is acceptable; no divider.
- Digit content by index:
  - Index 0: ones.
  - Index 1: tens; blank if tens==0 (leading-zero suppression), but DP=0 on this slot whenever V[4]=1 (even if tens is blanked).
  - Index 2: blank.
  - Index 3: blank.
  - DP=1 on all other slots.
- Blanking: while counter < BLANK_CYCLES, AN=4'b1111. Otherwise AN has only the bit for the current index at 0.
- Blank code: SEG=7'b1111111.
- Registered outputs: SEG, DP and AN are registered and change on the same edge as index/counter (one cycle after the counter value that selects them).
- Patterns (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Boundary conditions:
  - SUM changing mid-frame: no effect until the next frame boundary.
  - SUM changing exactly on the frame-boundary cycle: the value in sync stage 2 at that edge is taken.
  - Reset mid-slot: outputs go immediately (asynchronously) to reset values; after release, scanning restarts at index 0, counter 0, showing "0".
- No combinational path from SUM to any output.

Decomposition:
- Shared package seg7_pkg:
  - Segment pattern constants for 0..9.
  - SEG_BLANK.
  - DIGIT_BLANK code (4'hF).
  - Anode one-hot constants per index.
- One sub-module, seg7_decode: 4-bit digit code to 7-bit active-low pattern; any code >9 gives blank. Purely combinational, reusable by other display blocks.

Test Plan:
(bench uses REFRESH_COUNT=8, BLANK_CYCLES=2)
- Reset, then release with SUM=0. Required:
  - During reset: AN=1111, SEG=1111111, DP=1.
  - After release: index 0 slot shows SEG=1000000 on AN=1110, after 2 blank cycles.
  - Index 1..3 slots: AN active but SEG blank, DP=1.
- SUM=5'd23, wait one full frame. Required:
  - Index 0 shows 0110000 ("3").
  - Index 1 shows 0100100 ("2").
  - DP=0 on index 1 (V[4]=1).
- SUM=5'd7 then 5'd31, changed mid-frame. Required:
  - Display holds the previous value until the frame boundary.
  - Next frame shows ones "1" (1111001), tens "3" (0110000), DP=0 on index 1.
- SUM=5'd16. Required:
  - Ones "6" (0000010).
  - Tens "1" (1111001).
  - DP=0 on index 1.
- SUM=5'd9. Required:
  - Ones "9" (0010000).
  - Tens blank.
  - DP=1.
- Assert RST_N mid-slot while showing 23. Required:
  - Outputs go to reset values asynchronously, before the next CLK edge.
  - After release, the first frame displays "0" until the next frame boundary loads SUM.
